// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply engine and its Z drain stage.
package matmul_pkg;

   localparam int unsigned DATA_WIDTH_DEF  = 32;
   localparam int unsigned ADDR_WIDTH_DEF  = 12;
   localparam int unsigned VECTOR_SIZE_DEF = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } drain_state_t;

   function automatic int unsigned word_count(input int unsigned vector_size);
      return vector_size * vector_size;
   endfunction

endpackage

// File: rtl/matmul_drain_fifo.sv
// Small synchronous FIFO holding Z words between the BRAM read port and the output stream.
module matmul_drain_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // a push into a full FIFO is only accepted when a pop frees the slot that same cycle
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/matmul_z_drain.sv
// Streams the Z result BRAM out over valid/ready with an end-of-matrix marker.
// Optional MATMUL_DRAIN_CHECKSUM_EN adds a wrapping checksum of all streamed words.
module matmul_z_drain
   import matmul_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int unsigned VECTOR_SIZE = VECTOR_SIZE_DEF,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  done,
   output logic                  z_rd_en,
   output logic [ADDR_WIDTH-1:0] z_addr,
   input  logic [DATA_WIDTH-1:0] z_dout,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
`ifdef MATMUL_DRAIN_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] checksum
`endif
);

   localparam int unsigned N     = word_count(VECTOR_SIZE);
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] N_C    = CNT_W'(N);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N - 1);

   drain_state_t     state;
   drain_state_t     state_nxt;
   logic [CNT_W-1:0] issue_cnt;
   logic [CNT_W-1:0] accept_cnt;
   logic             inflight;
   logic [FC_W-1:0]  fifo_count;
   logic             credit_ok;
   logic             issue;
   logic             start_acc;
   logic             handshake;

   matmul_drain_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (FC_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (inflight),
      .push_data (z_dout),
      .pop       (handshake),
      .head      (out_data),
      .count     (fifo_count)
   );

   // credits count both stored words and the read still in the BRAM pipeline
   assign credit_ok = ({1'b0, fifo_count} + (FC_W + 1)'(inflight)) < (FC_W + 1)'(FIFO_DEPTH);
   assign out_valid = (fifo_count != '0);
   assign handshake = out_valid && out_ready;
   assign out_last  = out_valid && (accept_cnt == LAST_C);
   assign z_rd_en   = issue;
   assign z_addr    = issue_cnt[ADDR_WIDTH-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      start_acc = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            issue = (issue_cnt < N_C) && credit_ok;
            if (handshake && out_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            issue     = 1'bx;
            start_acc = 1'bx;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         issue_cnt  <= '0;
         accept_cnt <= '0;
         inflight   <= 1'b0;
         done       <= 1'b0;
      end else if (start_acc) begin
         issue_cnt  <= '0;
         accept_cnt <= '0;
         inflight   <= 1'b0;
         done       <= 1'b0;
      end else begin
         issue_cnt  <= issue_cnt + CNT_W'(issue);
         accept_cnt <= accept_cnt + CNT_W'(handshake);
         inflight   <= issue;
         if (state == DONE) begin
            done <= 1'b1;
         end
      end
   end

`ifdef MATMUL_DRAIN_CHECKSUM_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         checksum <= '0;
      end else if (start_acc) begin
         checksum <= '0;
      end else if (handshake) begin
         checksum <= checksum + out_data;
      end
   end
`endif

endmodule

// File: tb/tb_matmul_z_drain.sv
// Directed self-checking bench for matmul_z_drain with a 4x4 matrix and Z[a] = a + 100.
module tb_matmul_z_drain;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;
   localparam int unsigned VS = 4;
   localparam int unsigned FD = 4;
   localparam int          N  = 16;

   logic          clock;
   logic          reset;
   logic          start;
   logic          done;
   logic          z_rd_en;
   logic [AW-1:0] z_addr;
   logic [DW-1:0] z_dout;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
`ifdef MATMUL_DRAIN_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   int checks = 0;
   int errors = 0;

   matmul_z_drain #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .VECTOR_SIZE (VS),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .done      (done),
      .z_rd_en   (z_rd_en),
      .z_addr    (z_addr),
      .z_dout    (z_dout),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last)
`ifdef MATMUL_DRAIN_CHECKSUM_EN
      ,
      .checksum  (checksum)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Z BRAM model: one-cycle read latency
   always @(posedge clock) begin
      if (z_rd_en) z_dout <= DW'(z_addr) + 32'd100;
   end

   logic [DW-1:0] got [$];
   logic [DW-1:0] last_word;
   int  first_rd, first_valid, first_hs, last_hs, done_cyc;
   int  reads, reads_at10, last_cnt, last_bad;
   bit  credit_bad, stable_bad, addr_bad, done_at0, done_at1;

   // pat: 0 ready always, 1 ready toggling, 2 ready low 10 cycles, 3 start re-pulsed in RUN
   task automatic run_drain(input int pat);
      int       accepted;
      bit       prev_stall;
      logic [DW-1:0] prev_data;
      got.delete();
      first_rd = -1; first_valid = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
      reads = 0; reads_at10 = -1; last_cnt = 0; last_bad = 0; last_word = '0;
      credit_bad = 0; stable_bad = 0; addr_bad = 0; done_at0 = 0; done_at1 = 1;
      accepted = 0; prev_stall = 0; prev_data = '0;
      for (int c = 0; c < 200 && done_cyc < 0; c++) begin
         @(negedge clock);
         start = (c == 0) || (pat == 3 && c < 15 && (c % 2) == 0);
         case (pat)
            1:       out_ready = ((c % 2) == 0);
            2:       out_ready = (c > 10);
            default: out_ready = 1'b1;
         endcase
         #1;
         if (c == 0) done_at0 = done;
         if (c == 1) done_at1 = done;
         if (z_rd_en === 1'b1) begin
            if (first_rd < 0) first_rd = c;
            if (reads - accepted >= FD) credit_bad = 1;
            if (z_addr !== AW'(reads)) addr_bad = 1;
            reads++;
         end
         if (c == 10) reads_at10 = reads;
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stable_bad = 1;
         if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
         if (out_last === 1'b1 && (out_valid !== 1'b1 || accepted != N - 1)) last_bad++;
         if (out_valid === 1'b1 && out_ready) begin
            got.push_back(out_data);
            if (first_hs < 0) first_hs = c;
            last_hs = c;
            if (out_last === 1'b1) begin
               last_cnt++;
               last_word = out_data;
            end
            accepted++;
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data  = out_data;
         if (c >= 1 && done === 1'b1) done_cyc = c;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clock);
      #1;
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
      checks++; if (z_rd_en !== 1'b0)   begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", z_rd_en); end
      checks++; if (z_addr !== '0)      begin errors++; $display("FAIL reset_addr: got %0d expected 0", z_addr); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
      checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_last: got %0b expected 0", out_last); end
      checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
   endtask

   task automatic test_stream;
      run_drain(0);
      checks++; if (first_rd != 1)    begin errors++; $display("FAIL stream_first_rd: got %0d expected 1", first_rd); end
      checks++; if (first_valid != 3) begin errors++; $display("FAIL stream_first_valid: got %0d expected 3", first_valid); end
      checks++; if (got.size() != N)  begin errors++; $display("FAIL stream_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < got.size() && i < N; i++) begin
         checks++;
         if (got[i] !== DW'(100 + i)) begin errors++; $display("FAIL stream_word%0d: got %0d expected %0d", i, got[i], 100 + i); end
      end
      checks++; if (last_cnt != 1 || last_word !== 32'd115) begin errors++; $display("FAIL stream_last: got count %0d word %0d expected 1 and 115", last_cnt, last_word); end
      checks++; if (last_bad != 0)    begin errors++; $display("FAIL stream_last_spurious: got %0d expected 0", last_bad); end
      checks++; if (last_hs != 18)    begin errors++; $display("FAIL stream_last_hs: got %0d expected 18", last_hs); end
      checks++; if (done_cyc != 20)   begin errors++; $display("FAIL stream_done_cycle: got %0d expected 20", done_cyc); end
      checks++; if (addr_bad)         begin errors++; $display("FAIL stream_addr_seq: got out-of-order expected 0..15"); end
      checks++; if (reads != N)       begin errors++; $display("FAIL stream_reads: got %0d expected %0d", reads, N); end
`ifdef MATMUL_DRAIN_CHECKSUM_EN
      checks++; if (checksum !== 32'd1720) begin errors++; $display("FAIL checksum: got %0d expected 1720", checksum); end
`endif
   endtask

   task automatic test_toggle;
      run_drain(1);
      checks++; if (got.size() != N) begin errors++; $display("FAIL toggle_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < got.size() && i < N; i++) begin
         checks++;
         if (got[i] !== DW'(100 + i)) begin errors++; $display("FAIL toggle_word%0d: got %0d expected %0d", i, got[i], 100 + i); end
      end
      checks++; if (stable_bad)   begin errors++; $display("FAIL toggle_stable: got change under stall expected stable"); end
      checks++; if (credit_bad)   begin errors++; $display("FAIL toggle_credit: got over-issue expected <= %0d outstanding", FD); end
      checks++; if (done_cyc < 0) begin errors++; $display("FAIL toggle_done: got timeout expected done"); end
   endtask

   task automatic test_stall;
      run_drain(2);
      checks++; if (reads_at10 != FD) begin errors++; $display("FAIL stall_reads: got %0d expected %0d", reads_at10, FD); end
      checks++; if (first_hs != 11)   begin errors++; $display("FAIL stall_first_hs: got %0d expected 11", first_hs); end
      checks++; if (last_hs - first_hs != N - 1) begin errors++; $display("FAIL stall_full_rate: got span %0d expected %0d", last_hs - first_hs, N - 1); end
      checks++; if (got.size() != N)  begin errors++; $display("FAIL stall_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < got.size() && i < N; i++) begin
         checks++;
         if (got[i] !== DW'(100 + i)) begin errors++; $display("FAIL stall_word%0d: got %0d expected %0d", i, got[i], 100 + i); end
      end
      checks++; if (credit_bad || stable_bad) begin errors++; $display("FAIL stall_flow: got credit %0b stable %0b expected 0 0", credit_bad, stable_bad); end
   endtask

   task automatic test_reset_mid;
      int accepted = 0;
      @(negedge clock);
      start = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 50 && accepted < 7; c++) begin
         @(negedge clock);
         start = 1'b0;
         #1;
         if (out_valid === 1'b1) accepted++;
      end
      checks++; if (accepted != 7) begin errors++; $display("FAIL rstmid_reach: got %0d expected 7", accepted); end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++; if ({done, z_rd_en, out_valid, out_last} !== 4'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 0000", {done, z_rd_en, out_valid, out_last}); end
      checks++; if (z_addr !== '0 || out_data !== '0) begin errors++; $display("FAIL rstmid_data: got addr %0d data %0d expected 0 0", z_addr, out_data); end
      @(negedge clock);
      #1;
      checks++; if (out_valid !== 1'b0 || z_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_hold: got valid %0b rd %0b expected 0 0", out_valid, z_rd_en); end
      reset = 1'b1;
      repeat (2) @(negedge clock);
      run_drain(0);
      checks++; if (addr_bad || first_rd != 1) begin errors++; $display("FAIL rstmid_restart_addr: got first_rd %0d bad %0b expected 1 0", first_rd, addr_bad); end
      checks++; if (got.size() != N) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < got.size() && i < N; i++) begin
         checks++;
         if (got[i] !== DW'(100 + i)) begin errors++; $display("FAIL rstmid_word%0d: got %0d expected %0d", i, got[i], 100 + i); end
      end
   endtask

   task automatic test_ignore_start;
      run_drain(3);
      checks++; if (got.size() != N) begin errors++; $display("FAIL ignore_count: got %0d expected %0d", got.size(), N); end
      checks++; if (reads != N)      begin errors++; $display("FAIL ignore_reads: got %0d expected %0d", reads, N); end
      checks++; if (addr_bad)        begin errors++; $display("FAIL ignore_addr_seq: got restart expected 0..15"); end
      checks++; if (done_cyc != 20)  begin errors++; $display("FAIL ignore_done_cycle: got %0d expected 20", done_cyc); end
   endtask

   task automatic test_back_to_back;
      run_drain(0);
      checks++; if (done_at0 !== 1'b1) begin errors++; $display("FAIL b2b_done_held: got %0b expected 1", done_at0); end
      checks++; if (done_at1 !== 1'b0) begin errors++; $display("FAIL b2b_done_clear: got %0b expected 0", done_at1); end
      checks++; if (got.size() != N)   begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got.size(), N); end
      for (int i = 0; i < got.size() && i < N; i++) begin
         checks++;
         if (got[i] !== DW'(100 + i)) begin errors++; $display("FAIL b2b_word%0d: got %0d expected %0d", i, got[i], 100 + i); end
      end
      checks++; if (done_cyc != 20) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 20", done_cyc); end
`ifdef MATMUL_DRAIN_CHECKSUM_EN
      checks++; if (checksum !== 32'd1720) begin errors++; $display("FAIL b2b_checksum: got %0d expected 1720", checksum); end
`endif
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      test_reset;
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      test_stream;
      test_toggle;
      test_stall;
      test_reset_mid;
      test_ignore_start;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
